// File: rtl/tmr_counter_ctl_if.sv
// tmr_counter_ctl_if: control and status bundle for tmr_counter_ctl.
// TMR_FAULT_INJECT_EN adds the inj_en/inj_sel/inj_mask injection signals.
interface tmr_counter_ctl_if #(
    parameter int WIDTH  = 32,
    parameter int FCNT_W = 8
);
    logic              en;
    logic              up;
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              fault_clr;
    logic [WIDTH-1:0]  q_out;
    logic              tc;
    logic [2:0]        fault_sticky;
    logic [FCNT_W-1:0] fault_cnt;
    logic              multi_err;
`ifdef TMR_FAULT_INJECT_EN
    logic              inj_en;
    logic [1:0]        inj_sel;
    logic [WIDTH-1:0]  inj_mask;
    modport master (output en, up, clr, load, load_val, fault_clr, inj_en, inj_sel, inj_mask,
                    input q_out, tc, fault_sticky, fault_cnt, multi_err);
    modport slave  (input en, up, clr, load, load_val, fault_clr, inj_en, inj_sel, inj_mask,
                    output q_out, tc, fault_sticky, fault_cnt, multi_err);
`else
    modport master (output en, up, clr, load, load_val, fault_clr,
                    input q_out, tc, fault_sticky, fault_cnt, multi_err);
    modport slave  (input en, up, clr, load, load_val, fault_clr,
                    output q_out, tc, fault_sticky, fault_cnt, multi_err);
`endif
endinterface

// File: rtl/tmr_counter_ctl.sv
// tmr_counter_ctl: triple-redundant up/down modulo counter with voting, self-repair and fault status.
// Optional TMR_FAULT_INJECT_EN enables per-replica XOR fault injection.
module tmr_counter_ctl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter int               FCNT_W    = 8
) (
    input logic clk,
    input logic rst_n,
    tmr_counter_ctl_if.slave bus
);
    logic [WIDTH-1:0]  q0, q1, q2, r0, r1, r2, voted, nxt, m0, m1, m2;
    logic [2:0]        mis, sticky;
    logic [FCNT_W-1:0] fcnt;
    logic              multi, merr;
    assign r0 = q0;
    assign r1 = q1;
    assign r2 = q2;
    assign voted = (r0 & r1) | (r0 & r2) | (r1 & r2);
    assign mis = {r2 != voted, r1 != voted, r0 != voted};
    assign multi = (r0 != r1) && (r0 != r2) && (r1 != r2);
    // Every replica steps from the vote, so one upset replica is repaired on the next edge.
    assign nxt = bus.clr  ? '0 :
                 bus.load ? (bus.load_val > MAX_COUNT ? MAX_COUNT : bus.load_val) :
                 !bus.en  ? voted :
                 bus.up   ? (voted >= MAX_COUNT ? '0 : voted + 1'b1) :
                            (voted == '0 ? MAX_COUNT : voted - 1'b1);
`ifdef TMR_FAULT_INJECT_EN
    assign m0 = (bus.inj_en && bus.inj_sel == 2'd0) ? bus.inj_mask : '0;
    assign m1 = (bus.inj_en && bus.inj_sel == 2'd1) ? bus.inj_mask : '0;
    assign m2 = (bus.inj_en && bus.inj_sel == 2'd2) ? bus.inj_mask : '0;
`else
    assign m0 = '0;
    assign m1 = '0;
    assign m2 = '0;
`endif
    assign bus.q_out = voted;
    assign bus.tc = rst_n && bus.en && !bus.clr && !bus.load &&
                    (bus.up ? voted == MAX_COUNT : voted == '0);
    assign bus.fault_sticky = sticky;
    assign bus.fault_cnt = fcnt;
    assign bus.multi_err = merr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q0     <= '0;
            q1     <= '0;
            q2     <= '0;
            sticky <= '0;
            fcnt   <= '0;
            merr   <= 1'b0;
        end else begin
            q0     <= nxt ^ m0;
            q1     <= nxt ^ m1;
            q2     <= nxt ^ m2;
            sticky <= (bus.fault_clr ? 3'b000 : sticky) | mis;
            fcnt   <= bus.fault_clr ? FCNT_W'(|mis) : fcnt + FCNT_W'(|mis && fcnt != '1);
            merr   <= (!bus.fault_clr && merr) || multi;
        end
endmodule

// File: tb/tb_tmr_counter_ctl.sv
// tb_tmr_counter_ctl: directed bench for tmr_counter_ctl (WIDTH=4, MAX_COUNT=9, FCNT_W=2)
// checked every cycle against an arithmetic model, plus literal pins.
module tb_tmr_counter_ctl;
    localparam int MAXC = 9;
    localparam int FMAX = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    tmr_counter_ctl_if #(.WIDTH(4), .FCNT_W(2)) bus ();
    tmr_counter_ctl #(.WIDTH(4), .MAX_COUNT(4'd9), .FCNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int         cur = 0;
    logic [2:0] st = '0;
    int         fc = 0;
    logic       me = 1'b0;
    logic [3:0] fm [3] = '{default: 4'h0};
    logic [3:0] im [3] = '{default: 4'h0};
    logic [3:0] fv0, fv1, fv2;

    function automatic logic [3:0] rep(int r);
        return 4'(cur) ^ fm[r] ^ im[r];
    endfunction
    function automatic logic [3:0] vote();
        return (rep(0) & rep(1)) | (rep(0) & rep(2)) | (rep(1) & rep(2));
    endfunction
    function automatic logic [2:0] mism();
        return {rep(2) != vote(), rep(1) != vote(), rep(0) != vote()};
    endfunction
    function automatic int next_of(int v);
        if (bus.clr) return 0;
        if (bus.load) return int'(bus.load_val) > MAXC ? MAXC : int'(bus.load_val);
        if (!bus.en) return v;
        if (bus.up) return v >= MAXC ? 0 : v + 1;
        return v == 0 ? MAXC : v - 1;
    endfunction
    function automatic bit exp_tc();
        return rst_n && bus.en && !bus.clr && !bus.load &&
               (bus.up ? int'(vote()) == MAXC : vote() == 4'h0);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur <= 0;
            st  <= '0;
            fc  <= 0;
            me  <= 1'b0;
            for (int i = 0; i < 3; i++) im[i] <= 4'h0;
        end else begin
            cur <= next_of(int'(vote()));
            st  <= (bus.fault_clr ? 3'b000 : st) | mism();
            fc  <= bus.fault_clr ? int'(|mism()) : (|mism() && fc < FMAX) ? fc + 1 : fc;
            me  <= (!bus.fault_clr && me) || (rep(0) != rep(1) && rep(0) != rep(2) && rep(1) != rep(2));
`ifdef TMR_FAULT_INJECT_EN
            for (int i = 0; i < 3; i++) im[i] <= (bus.inj_en && bus.inj_sel == 2'(i)) ? bus.inj_mask : 4'h0;
`endif
        end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        chk("model q_out", int'(bus.q_out), int'(vote()));
        chk("model tc", int'(bus.tc), int'(exp_tc()));
        chk("model sticky", int'(bus.fault_sticky), int'(st));
        chk("model fault_cnt", int'(bus.fault_cnt), fc);
        chk("model multi_err", int'(bus.multi_err), int'(me));
    end

    task automatic drive(bit e, bit u, bit c, bit l, int lv, bit f);
        bus.en = e;
        bus.up = u;
        bus.clr = c;
        bus.load = l;
        bus.load_val = 4'(lv);
        bus.fault_clr = f;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        release dut.r0;
        release dut.r1;
        release dut.r2;
        for (int i = 0; i < 3; i++) fm[i] = 4'h0;
        @(negedge clk);
    endtask
    task automatic upset(int r, logic [3:0] m);
        fm[r] = m;
        case (r)
            0: begin fv0 = 4'(cur) ^ m; force dut.r0 = fv0; end
            1: begin fv1 = 4'(cur) ^ m; force dut.r1 = fv1; end
            default: begin fv2 = 4'(cur) ^ m; force dut.r2 = fv2; end
        endcase
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
`ifdef TMR_FAULT_INJECT_EN
        bus.inj_en = 1'b0;
        bus.inj_sel = 2'd3;
        bus.inj_mask = 4'h0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset q_out", int'(bus.q_out), 0);
        chk("reset sticky", int'(bus.fault_sticky), 0);
        chk("reset fault_cnt", int'(bus.fault_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("up q_out", int'(bus.q_out), k % 10);
            chk("up tc", int'(bus.tc), int'(k % 10 == 9));
            tick();
        end
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("load 1", int'(bus.q_out), 1);
        drive(1, 0, 0, 0, 0, 0);
        #1 chk("down tc at 1", int'(bus.tc), 0);
        tick();
        chk("down 0", int'(bus.q_out), 0);
        #1 chk("down tc at 0", int'(bus.tc), 1);
        tick();
        chk("down wrap 9", int'(bus.q_out), 9);
        tick();
        chk("down 8", int'(bus.q_out), 8);
        drive(0, 0, 1, 1, 5, 0);
        tick();
        chk("clr over load", int'(bus.q_out), 0);
        drive(0, 0, 0, 1, 15, 0);
        tick();
        chk("load clamp", int'(bus.q_out), 9);
        drive(1, 1, 0, 1, 3, 0);
        #1 chk("load masks tc", int'(bus.tc), 0);
        tick();
        chk("load over en", int'(bus.q_out), 3);
        drive(1, 1, 0, 0, 0, 0);
        upset(1, 4'b1000);
        #1 chk("upset voted", int'(bus.q_out), 3);
        tick();
        chk("upset q_out", int'(bus.q_out), 4);
        chk("upset sticky", int'(bus.fault_sticky), 3'b010);
        chk("upset fault_cnt", int'(bus.fault_cnt), 1);
        tick();
        chk("repaired q_out", int'(bus.q_out), 5);
        chk("repaired fault_cnt", int'(bus.fault_cnt), 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            upset(0, 4'b0001);
            tick();
        end
        chk("sat fault_cnt", int'(bus.fault_cnt), 3);
        chk("sat sticky", int'(bus.fault_sticky), 3'b011);
        chk("hold q_out", int'(bus.q_out), 5);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("fclr sticky", int'(bus.fault_sticky), 0);
        chk("fclr fault_cnt", int'(bus.fault_cnt), 0);
        upset(2, 4'b0010);
        tick();
        chk("fclr+mis fault_cnt", int'(bus.fault_cnt), 1);
        chk("fclr+mis sticky", int'(bus.fault_sticky), 3'b100);
        drive(0, 0, 0, 0, 0, 0);
        upset(1, 4'b0001);
        upset(2, 4'b0010);
        tick();
        chk("triple multi_err", int'(bus.multi_err), 1);
        chk("triple q_out", int'(bus.q_out), 5);
        chk("triple sticky", int'(bus.fault_sticky), 3'b110);
        tick();
        chk("multi_err sticky", int'(bus.multi_err), 1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("multi_err clr", int'(bus.multi_err), 0);
        drive(0, 0, 0, 0, 0, 0);
        upset(1, 4'b0001);
        upset(2, 4'b0010);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("pre-reset q_out", int'(bus.q_out), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("async q_out", int'(bus.q_out), 0);
        chk("async tc", int'(bus.tc), 0);
        chk("async sticky", int'(bus.fault_sticky), 0);
        chk("async fault_cnt", int'(bus.fault_cnt), 0);
        chk("async multi_err", int'(bus.multi_err), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
`ifdef TMR_FAULT_INJECT_EN
        drive(1, 1, 0, 0, 0, 0);
        bus.inj_en = 1'b1;
        bus.inj_sel = 2'd1;
        bus.inj_mask = 4'b1000;
        tick();
        bus.inj_en = 1'b0;
        chk("inj q_out", int'(bus.q_out), 1);
        tick();
        chk("inj repaired q_out", int'(bus.q_out), 2);
        chk("inj sticky", int'(bus.fault_sticky), 3'b010);
        chk("inj fault_cnt", int'(bus.fault_cnt), 1);
`endif
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tmr_counter_ctl.md
Name: tmr_counter_ctl

Overview:
Parametrised triple-modular-redundant counter, successor to the fixed 32-bit TMR up-counter.
- Adds up/down counting, a programmable modulus, synchronous load and clear, and a terminal-count pulse.
- Adds fault observability: per-replica sticky flags, a saturating fault-event counter, and a multi-disagreement flag.
- Sits in the rad-hardened datapath as the timebase/event counter; q_out feeds downstream logic directly.

Parameters:
WIDTH, 32, counter width in bits
MAX_COUNT, 2**WIDTH-1, terminal value; counter range is 0..MAX_COUNT (must be >= 1)
FCNT_W, 8, width of the saturating fault-event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable
up  in  1  direction: 1 = up, 0 = down
clr  in  1  synchronous clear to 0
load  in  1  synchronous load
load_val  in  WIDTH  value loaded when load=1
fault_clr  in  1  clears fault_sticky, multi_err and fault_cnt
q_out  out  WIDTH  voted count
tc  out  1  terminal-count pulse (combinational)
fault_sticky  out  3  bit r set when replica r has disagreed with the vote
fault_cnt  out  FCNT_W  number of cycles with any replica mismatch, saturating
multi_err  out  1  sticky; all three replicas pairwise different

Behaviour:
Reset (rst_n=0, asynchronous):
- Replicas q0..q2 = 0; q_out = 0, tc = 0, fault_sticky = 0, fault_cnt = 0, multi_err = 0.
- Deassertion takes effect at the next clock edge.

Voter (combinational):
- voted = bitwise majority of q0, q1, q2.
- mis_r = (q_r != voted).
- q_out = voted.

Per-replica base value:
- base_r = mis_r ? voted : q_r.
- Every replica updates from base_r, so a single corrupted replica is repaired on the next edge whether or not en=1.

Next value, in priority order:
- clr: 0
- else load: min(load_val, MAX_COUNT)
- else en & up: base_r == MAX_COUNT ? 0 : base_r + 1
- else en & !up: base_r == 0 ? MAX_COUNT : base_r - 1
- else: base_r (hold; still repairs)
- Arithmetic is modulo MAX_COUNT+1. If a replica holds a value above MAX_COUNT (upset), an up-count wraps it to 0 and a down-count decrements normally.

tc:
- tc = en & !clr & !load & (up ? voted == MAX_COUNT : voted == 0).
- High exactly in the cycle before the wrap edge.

Fault status, sampled each edge:
- fault_sticky[r] is set if mis_r.
- fault_cnt increments by 1 if any mis_r, saturating at 2**FCNT_W-1.
- multi_err is set if q0!=q1, q0!=q2 and q1!=q2.
- In that case voted is the bitwise majority, which may match no replica. All three replicas reload from it; no further guarantee is given.
- fault_clr=1 clears all three fault outputs. A mismatch in the same cycle wins: the sticky bit reads 1 and fault_cnt reads 1 after the edge.

Latency: one cycle from control input to q_out.

Optional Feature:
TMR_FAULT_INJECT_EN. When defined, three extra ports are present:
- inj_en (in, 1), inj_sel (in, 2), inj_mask (in, WIDTH).
- When inj_en=1, replica inj_sel (0..2; value 3 = none) stores next_value XOR inj_mask at the edge.
- The injected error is visible on the following cycle and repaired one cycle later.

When not defined, these ports do not exist and there is no injection logic.

Test Plan:
1. Reset and count up, WIDTH=4, MAX_COUNT=9: rst_n low, then en=1, up=1 for 12 cycles -> q_out 0..9, 0, 1; tc high while q_out=9; all fault outputs 0.
2. Down count and wrap: load_val=1, load=1; then en=1, up=0 -> q_out 1, 0, 9, 8; tc high while q_out=0.
3. Priority and clamp:
   - clr=1, load=1, load_val=5 -> q_out 0.
   - load=1, load_val=15 -> q_out 9 (clamped).
   - en=1 with load=1 -> the load wins.
4. Single-replica injection (TMR_FAULT_INJECT_EN), counter at 3, inj_sel=1, inj_mask=4'b1000, en=1 -> q_out stays correct (4, 5, ...); fault_sticky=3'b010, fault_cnt=1; replica 1 is repaired one cycle after the upset.
5. Fault counter behaviour:
   - Repeated injections with FCNT_W=2 -> fault_cnt saturates at 3.
   - fault_clr pulse -> all fault outputs 0.
   - fault_clr in the same cycle as a mismatch -> fault_cnt=1.
6. Triple disagreement: inject distinct masks into two replicas on the same edge (or force them in the bench) -> multi_err=1 and stays 1 until fault_clr; asynchronous rst_n mid-count -> all outputs 0 immediately.
